// File: rtl/haar_pkg.sv
// rtl/haar_pkg.sv - shared record layout, evaluator states and saturating add
package haar_pkg;

  localparam int REC_WORDS  = 18;
  localparam int RECT_WORDS = 15;
  localparam int THR_OFF    = 15;
  localparam int LEFT_OFF   = 16;
  localparam int RIGHT_OFF  = 17;

  typedef enum logic [3:0] {
    S_IDLE,
    S_REQ,
    S_LOAD,
    S_FEAT_REQ,
    S_FEAT_WAIT,
    S_ACCUM,
    S_THR_REQ,
    S_THR_LOAD,
    S_DONE
  } haar_state_t;

  // Overflow shows up as disagreement between the carry-out and the sign bit.
  function automatic logic signed [15:0] sat_add16(input logic signed [15:0] a,
                                                   input logic signed [15:0] b);
    logic [16:0] sum;
    sum = {a[15], a} + {b[15], b};
    if (sum[16] != sum[15]) return sum[16] ? 16'sh8000 : 16'sh7fff;
    return sum[15:0];
  endfunction

endpackage

// File: rtl/haar_record_buffer.sv
// rtl/haar_record_buffer.sv - one classifier record held as 18 words
module haar_record_buffer
  import haar_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = REC_WORDS
) (
  input  logic                        clk_fpga,
  input  logic                        reset_fpga,
  input  logic                        clear,
  input  logic                        wr_en,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  output logic [DEPTH*DATA_WIDTH-1:0] words,
  output logic                        last,
  output logic                        full
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]         wr_count;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign full = (wr_count == CW'(DEPTH));
  assign last = wr_en && !full && (wr_count == CW'(DEPTH - 1));

  always_ff @(posedge clk_fpga) begin
    if (!reset_fpga) begin
      wr_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_count <= '0;
    end else if (wr_en && !full) begin
      mem[wr_count] <= wr_data;
      wr_count      <= wr_count + CW'(1);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_words
    assign words[g*DATA_WIDTH +: DATA_WIDTH] = mem[g];
  end

endmodule

// File: rtl/haar_stage_evaluator.sv
// rtl/haar_stage_evaluator.sv - walks one cascade stage's records and votes on a window
module haar_stage_evaluator
  import haar_pkg::*;
#(
  parameter int ADDR_WIDTH               = 12,
  parameter int DATA_WIDTH_12            = 12,
  parameter int DATA_WIDTH_16            = 16,
  parameter int NUM_CLASSIFIERS_STAGE    = 32,
  parameter int NUM_PARAM_PER_CLASSIFIER = 18,
  parameter int NUM_STAGE_THRESHOLD      = 3
) (
  input  logic                                clk_fpga,
  input  logic                                reset_fpga,
  input  logic                                i_start,
  output logic                                o_rden,
  input  logic                                i_data_valid,
  input  logic [DATA_WIDTH_12-1:0]            i_data_database,
  output logic                                o_rect_valid,
  input  logic                                i_rect_ready,
  output logic [RECT_WORDS*DATA_WIDTH_12-1:0] o_rect_params,
  input  logic                                i_feature_valid,
  input  logic signed [DATA_WIDTH_16-1:0]     i_feature_value,
  output logic                                o_busy,
  output logic                                o_stage_done,
  output logic                                o_stage_pass,
  output logic signed [DATA_WIDTH_16-1:0]     o_stage_sum
);

  localparam int DW = DATA_WIDTH_12;
  localparam int EW = DATA_WIDTH_16 - DATA_WIDTH_12;
  localparam int TW = $clog2(NUM_STAGE_THRESHOLD) + 1;

  haar_state_t                       state;
  logic [ADDR_WIDTH-1:0]             cls_idx;
  logic signed [DATA_WIDTH_16-1:0]   acc;
  logic [DW-1:0]                     thr_q;
  logic [TW-1:0]                     thr_cnt;
  logic [NUM_PARAM_PER_CLASSIFIER*DW-1:0] rec_words;
  logic                              rec_clear, rec_wr, rec_last, rec_full;
  logic [DW-1:0]                     w_thr, w_left, w_right, stage_thr_word;
  logic signed [DATA_WIDTH_16-1:0]   cls_thr, vote, stage_thr;

  assign rec_clear = (state == S_REQ);
  assign rec_wr    = (state == S_LOAD) && i_data_valid && !rec_full;

  haar_record_buffer #(
    .DATA_WIDTH (DW),
    .DEPTH      (NUM_PARAM_PER_CLASSIFIER)
  ) u_record_buffer (
    .clk_fpga   (clk_fpga),
    .reset_fpga (reset_fpga),
    .clear      (rec_clear),
    .wr_en      (rec_wr),
    .wr_data    (i_data_database),
    .words      (rec_words),
    .last       (rec_last),
    .full       (rec_full)
  );

  assign o_rect_params = rec_words[RECT_WORDS*DW-1:0];
  assign w_thr   = rec_words[THR_OFF*DW   +: DW];
  assign w_left  = rec_words[LEFT_OFF*DW  +: DW];
  assign w_right = rec_words[RIGHT_OFF*DW +: DW];
  assign cls_thr = {{EW{w_thr[DW-1]}}, w_thr};
  assign vote    = (i_feature_value < cls_thr) ? {{EW{w_left[DW-1]}}, w_left}
                                               : {{EW{w_right[DW-1]}}, w_right};

  // The threshold may still be on the bus if it is also the last trailing word.
  assign stage_thr_word = (thr_cnt == '0) ? i_data_database : thr_q;
  assign stage_thr      = {{EW{stage_thr_word[DW-1]}}, stage_thr_word};

  always_ff @(posedge clk_fpga) begin
    if (!reset_fpga) begin
      state        <= S_IDLE;
      o_rden       <= 1'b0;
      o_rect_valid <= 1'b0;
      o_busy       <= 1'b0;
      o_stage_done <= 1'b0;
      o_stage_pass <= 1'b0;
      o_stage_sum  <= '0;
      acc          <= '0;
      cls_idx      <= '0;
      thr_q        <= '0;
      thr_cnt      <= '0;
    end else begin
      o_rden       <= 1'b0;
      o_stage_done <= 1'b0;
      case (state)
        S_IDLE: if (i_start) begin
          state        <= S_REQ;
          o_rden       <= 1'b1;
          o_busy       <= 1'b1;
          acc          <= '0;
          cls_idx      <= '0;
          o_stage_pass <= 1'b0;
          o_stage_sum  <= '0;
        end
        S_REQ: state <= S_LOAD;
        S_LOAD: if (rec_last) begin
          state        <= S_FEAT_REQ;
          o_rect_valid <= 1'b1;
        end
        S_FEAT_REQ: if (i_rect_ready) begin
          state        <= S_FEAT_WAIT;
          o_rect_valid <= 1'b0;
        end
        S_FEAT_WAIT: if (i_feature_valid) begin
          acc   <= sat_add16(acc, vote);
          state <= S_ACCUM;
        end
        S_ACCUM: begin
          cls_idx <= cls_idx + ADDR_WIDTH'(1);
          o_rden  <= 1'b1;
          state   <= (cls_idx == ADDR_WIDTH'(NUM_CLASSIFIERS_STAGE - 1)) ? S_THR_REQ : S_REQ;
        end
        S_THR_REQ: begin
          thr_cnt <= '0;
          state   <= S_THR_LOAD;
        end
        S_THR_LOAD: if (i_data_valid) begin
          if (thr_cnt == '0) thr_q <= i_data_database;
          thr_cnt <= thr_cnt + TW'(1);
          if (thr_cnt == TW'(NUM_STAGE_THRESHOLD - 1)) begin
            state        <= S_DONE;
            o_stage_done <= 1'b1;
            o_stage_pass <= (acc >= stage_thr);
            o_stage_sum  <= acc;
          end
        end
        S_DONE: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
